// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci sequencer: default widths and FSM state encoding.
package fib_pkg;

    localparam int FIB_WIDTH = 4;
    localparam int FIB_CNT_W = 5;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage : fib_pkg

// File: rtl/fib_sequencer.sv
// Register/control stage in front of an external ripple-carry adder: holds the prev/curr
// Fibonacci pair, streams one term per clock and stops early with a sticky overflow flag.
module fib_sequencer
    import fib_pkg::*;
#(
    parameter int WIDTH = FIB_WIDTH,
    parameter int CNT_W = FIB_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] n_terms,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    output logic [WIDTH-1:0] fib_out,
    output logic             fib_valid,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] curr_q, curr_d;
    logic             prev_ovf_q, prev_ovf_d;
    logic             curr_ovf_q, curr_ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [WIDTH-1:0] fib_out_q, fib_out_d;
    logic             fib_valid_q, fib_valid_d;
    logic             done_q, done_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] cnt_inc;

    // n_terms never exceeds 2^CNT_W-1, so the incremented count cannot wrap.
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        // NOTE: every _d gets a default before the case so no path leaves one unassigned (no latches).
        state_d     = state_q;
        prev_d      = prev_q;
        curr_d      = curr_q;
        prev_ovf_d  = prev_ovf_q;
        curr_ovf_d  = curr_ovf_q;
        cnt_d       = cnt_q;
        n_d         = n_q;
        fib_out_d   = fib_out_q;
        overflow_d  = overflow_q;
        fib_valid_d = 1'b0;
        done_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    n_d        = n_terms;
                    prev_d     = '0;
                    curr_d     = WIDTH'(1);
                    prev_ovf_d = 1'b0;
                    curr_ovf_d = 1'b0;
                    cnt_d      = '0;
                    overflow_d = 1'b0;
                    if (n_terms == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end

            RUN: begin
                // The done cycle is spent in RUN so busy stays high with done and a start there is ignored.
                if (done_q) begin
                    state_d = IDLE;
                end else if (prev_ovf_q) begin
                    overflow_d = 1'b1;
                    done_d     = 1'b1;
                end else begin
                    fib_out_d   = prev_q;
                    fib_valid_d = 1'b1;
                    cnt_d       = cnt_inc;
                    prev_d      = curr_q;
                    prev_ovf_d  = curr_ovf_q;
                    curr_d      = add_sum;
                    curr_ovf_d  = add_cout | prev_ovf_q | curr_ovf_q;
                    if (cnt_inc == n_q) begin
                        done_d = 1'b1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            prev_q      <= '0;
            curr_q      <= '0;
            prev_ovf_q  <= 1'b0;
            curr_ovf_q  <= 1'b0;
            cnt_q       <= '0;
            n_q         <= '0;
            fib_out_q   <= '0;
            fib_valid_q <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            curr_q      <= curr_d;
            prev_ovf_q  <= prev_ovf_d;
            curr_ovf_q  <= curr_ovf_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            fib_out_q   <= fib_out_d;
            fib_valid_q <= fib_valid_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
        end
    end

    assign add_a     = prev_q;
    assign add_b     = curr_q;
    assign fib_out   = fib_out_q;
    assign fib_valid = fib_valid_q;
    assign busy      = (state_q == RUN);
    assign done      = done_q;
    assign overflow  = overflow_q;

endmodule : fib_sequencer
